// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Synchronous data memory for the load/store unit. Requests use a
//   valid/ready handshake and may carry per-byte write strobes. Every
//   accepted request gets exactly one registered response on the
//   following cycle. After reset the array is zero-filled one word per
//   cycle, and requests are refused until the fill completes.
//
// Ports
//   clk        : single rising-edge clock
//   rst        : synchronous, active-high reset
//   req_valid  : request present this cycle
//   req_ready  : controller accepts requests (high once the fill is done)
//   req_we     : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   req_be     : byte strobes, bit i enables bits 8i+7:8i
//   rsp_valid  : one-cycle response pulse
//   rsp_rdata  : read data; 0 for writes and errors
//   rsp_err    : address was out of range (req_addr >= DEPTH)
//   busy       : zero-fill in progress
module data_mem_ctrl #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 8,
  parameter  int DEPTH  = 256,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  // The counter and the range bound are one bit wider than the address
  // so that DEPTH = 2**ADDR_W can be represented without wrapping.
  localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [0:0]        state;
  logic [ADDR_W:0]   fill_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              in_range;

  // A request presented on a reset edge is not taken, so it can neither
  // modify the array nor produce a response.
  assign accept    = (state == IDLE) && req_valid && !rst;
  assign in_range  = {1'b0, req_addr} < DEPTH_EXT;
  assign busy      = (state == CLEAR);
  assign req_ready = (state == IDLE);

  // Fill sequencer: walks the counter from 0 to DEPTH-1, then opens the
  // port. A reset at any point restarts the walk from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      fill_cnt <= '0;
    end else if (state == CLEAR) begin
      fill_cnt <= fill_cnt + 1'b1;
      if (fill_cnt == FILL_LAST) begin
        state <= IDLE;
      end
    end
  end

  // RAM array. This block has no reset so that it maps onto block RAM;
  // clearing is done by the fill sequence instead. The fill write during
  // a reset cycle is harmless because the fill restarts from word 0.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[fill_cnt[ADDR_W-1:0]] <= '0;
    end else if (accept && req_we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered response. It is issued one cycle after acceptance. A write
  // on the previous edge is already in the array, so a following read
  // sees the merged word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && !in_range;
      if (accept && !req_we && in_range) begin
        rsp_rdata <= mem[req_addr];
      end else begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
//   Directed, table-driven bench for data_mem_ctrl. It uses two instances
//   that share the clock and the reset. dut_a has the default DEPTH=256;
//   dut_b has DEPTH=200, so the out-of-range behaviour is reachable on
//   dut_b.
module tb_data_mem_ctrl;

  typedef struct {
    logic        valid;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        exp_valid;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid_a = 1'b0, req_we_a = 1'b0;
  logic [7:0]  req_addr_a = '0;
  logic [15:0] req_wdata_a = '0;
  logic [1:0]  req_be_a = '0;
  logic        req_ready_a, rsp_valid_a, rsp_err_a, busy_a;
  logic [15:0] rsp_rdata_a;

  logic        req_valid_b = 1'b0, req_we_b = 1'b0;
  logic [7:0]  req_addr_b = '0;
  logic [15:0] req_wdata_b = '0;
  logic [1:0]  req_be_b = '0;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
  logic [15:0] rsp_rdata_b;

  int pass_count  = 0;
  int check_count = 0;

  vec_t vecs_a[$];
  vec_t vecs_b[$];

  always #5 clk = ~clk;

  data_mem_ctrl dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_be(req_be_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .busy(busy_a)
  );

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_be(req_be_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .busy(busy_b)
  );

  function automatic vec_t mk(logic valid, logic we, logic [7:0] addr,
                              logic [15:0] wdata, logic [1:0] be,
                              logic exp_valid, logic [15:0] exp_rdata,
                              logic exp_err);
    vec_t v;
    v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_valid = exp_valid; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_count++;
    end
  endtask

  // Drive one request on the selected instance and hold the other one idle.
  task automatic applyStimulus(input vec_t v, input bit sel_b);
    req_valid_a = sel_b ? 1'b0 : v.valid;
    req_we_a    = v.we;    req_addr_a = v.addr;
    req_wdata_a = v.wdata; req_be_a   = v.be;
    req_valid_b = sel_b ? v.valid : 1'b0;
    req_we_b    = v.we;    req_addr_b = v.addr;
    req_wdata_b = v.wdata; req_be_b   = v.be;
  endtask

  // Apply one vector, step one edge and check the response it produced.
  // Vectors are issued on consecutive cycles with no idle cycles between them.
  task automatic runVector(input vec_t v, input bit sel_b, input string tag);
    applyStimulus(v, sel_b);
    @(posedge clk); #1;
    if (sel_b) begin
      checkOutput({tag, ".valid"}, 32'(rsp_valid_b), 32'(v.exp_valid));
      checkOutput({tag, ".rdata"}, 32'(rsp_rdata_b), 32'(v.exp_rdata));
      checkOutput({tag, ".err"},   32'(rsp_err_b),   32'(v.exp_err));
    end else begin
      checkOutput({tag, ".valid"}, 32'(rsp_valid_a), 32'(v.exp_valid));
      checkOutput({tag, ".rdata"}, 32'(rsp_rdata_a), 32'(v.exp_rdata));
      checkOutput({tag, ".err"},   32'(rsp_err_a),   32'(v.exp_err));
    end
  endtask

  // Count edges after reset release until each busy drops. The wait is
  // bounded; an instance that never finishes reports -1.
  task automatic waitFill(output int n_a, output int n_b);
    n_a = -1; n_b = -1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk); #1;
      if (n_a < 0 && !busy_a) n_a = n;
      if (n_b < 0 && !busy_b) n_b = n;
      if (n_a >= 0 && n_b >= 0) break;
    end
  endtask

  initial begin
    int   n_a, n_b;
    vec_t idle;
    idle = mk(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0);

    // Table for dut_a (DEPTH=256)
    vecs_a.push_back(mk(1, 0, 8'h00, 16'h0000, 2'b00, 1, 16'h0000, 0));
    vecs_a.push_back(mk(1, 0, 8'hFF, 16'h0000, 2'b00, 1, 16'h0000, 0));
    vecs_a.push_back(mk(1, 1, 8'h10, 16'hBEEF, 2'b11, 1, 16'h0000, 0));
    vecs_a.push_back(mk(1, 0, 8'h10, 16'h0000, 2'b00, 1, 16'hBEEF, 0));
    vecs_a.push_back(mk(1, 1, 8'h20, 16'h1234, 2'b11, 1, 16'h0000, 0));
    vecs_a.push_back(mk(1, 1, 8'h20, 16'hABCD, 2'b10, 1, 16'h0000, 0));
    vecs_a.push_back(mk(1, 0, 8'h20, 16'h0000, 2'b00, 1, 16'hAB34, 0));
    vecs_a.push_back(mk(1, 1, 8'h20, 16'hFFFF, 2'b00, 1, 16'h0000, 0));
    vecs_a.push_back(mk(1, 0, 8'h20, 16'h0000, 2'b00, 1, 16'hAB34, 0));
    vecs_a.push_back(mk(1, 1, 8'h21, 16'h5566, 2'b01, 1, 16'h0000, 0));
    vecs_a.push_back(mk(1, 0, 8'h21, 16'h0000, 2'b00, 1, 16'h0066, 0));
    vecs_a.push_back(idle);
    for (int i = 0; i < 8; i++)
      vecs_a.push_back(mk(1, 1, 8'(i), 16'(i * 16'h0101), 2'b11, 1, 16'h0000, 0));
    for (int i = 0; i < 8; i++)
      vecs_a.push_back(mk(1, 0, 8'(i), 16'h0000, 2'b00, 1, 16'(i * 16'h0101), 0));
    vecs_a.push_back(idle);

    // Table for dut_b (DEPTH=200): 0xC8 is the first out-of-range word
    vecs_b.push_back(mk(1, 0, 8'hC8, 16'h0000, 2'b00, 1, 16'h0000, 1));
    vecs_b.push_back(mk(1, 1, 8'hC8, 16'hFFFF, 2'b11, 1, 16'h0000, 1));
    vecs_b.push_back(mk(1, 0, 8'h00, 16'h0000, 2'b00, 1, 16'h0000, 0));
    vecs_b.push_back(mk(1, 0, 8'hC7, 16'h0000, 2'b00, 1, 16'h0000, 0));
    vecs_b.push_back(mk(1, 1, 8'hC7, 16'h1111, 2'b11, 1, 16'h0000, 0));
    vecs_b.push_back(mk(1, 0, 8'hC7, 16'h0000, 2'b00, 1, 16'h1111, 0));
    vecs_b.push_back(mk(1, 0, 8'hFF, 16'h0000, 2'b00, 1, 16'h0000, 1));
    vecs_b.push_back(idle);

    // Reset state and the initial fill
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst.busy",      32'(busy_a),      32'd1);
    checkOutput("rst.req_ready", 32'(req_ready_a), 32'd0);
    checkOutput("rst.rsp_valid", 32'(rsp_valid_a), 32'd0);
    checkOutput("rst.rsp_rdata", 32'(rsp_rdata_a), 32'd0);
    checkOutput("rst.rsp_err",   32'(rsp_err_a),   32'd0);
    rst = 1'b0;
    waitFill(n_a, n_b);
    checkOutput("fill.cycles_a", 32'(n_a), 32'd256);
    checkOutput("fill.cycles_b", 32'(n_b), 32'd200);
    checkOutput("fill.ready_a",  32'(req_ready_a), 32'd1);

    foreach (vecs_a[i]) runVector(vecs_a[i], 1'b0, $sformatf("a[%0d]", i));
    foreach (vecs_b[i]) runVector(vecs_b[i], 1'b1, $sformatf("b[%0d]", i));

    // Reset on the cycle after a read is accepted: the response that is
    // already showing is dropped on the reset edge, and 0x10 is cleared again.
    applyStimulus(mk(1, 0, 8'h10, 16'h0000, 2'b00, 0, 16'h0000, 0), 1'b0);
    @(posedge clk); #1;
    checkOutput("midtraffic.resp", 32'(rsp_rdata_a), 32'h0000BEEF);
    applyStimulus(idle, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midtraffic.valid_drop", 32'(rsp_valid_a), 32'd0);
    checkOutput("midtraffic.busy",       32'(busy_a),      32'd1);
    rst = 1'b0;
    waitFill(n_a, n_b);
    checkOutput("midtraffic.fill_a", 32'(n_a), 32'd256);
    runVector(mk(1, 0, 8'h10, 16'h0000, 2'b00, 1, 16'h0000, 0), 1'b0, "midtraffic.read10");

    // Reset at fill cycle 100, with a write request held throughout the fill
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(mk(1, 1, 8'h30, 16'hFFFF, 2'b11, 0, 16'h0000, 0), 1'b0);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("midfill.busy100",  32'(busy_a),      32'd1);
    checkOutput("midfill.ignored",  32'(rsp_valid_a), 32'd0);
    checkOutput("midfill.ready100", 32'(req_ready_a), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    waitFill(n_a, n_b);
    applyStimulus(idle, 1'b0);
    checkOutput("midfill.fill_a", 32'(n_a), 32'd256);
    checkOutput("midfill.fill_b", 32'(n_b), 32'd200);
    runVector(mk(1, 0, 8'h30, 16'h0000, 2'b00, 1, 16'h0000, 0), 1'b0, "midfill.read30");
    runVector(idle, 1'b0, "midfill.idle");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
